// File: rtl/ac_motor_pwm_compare.sv
// Multi-phase PWM comparator: shadowed sine references against the shared
// triangle carrier, with per-half-bridge dead-time sequencing.
module ac_motor_pwm_compare #(
  parameter int PHASES    = 3,
  parameter int CARRIER_W = 25,
  parameter int REF_W     = 24,
  parameter int DT_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      dir_ccw,
  input  logic [CARRIER_W-1:0]      carrier,
  input  logic                      carrier_peak,
  input  logic                      carrier_valley,
  input  logic [PHASES*REF_W-1:0]   refs,
  input  logic [DT_W-1:0]           dead_time,
  input  logic                      update_req,
  output logic                      update_ack,
  output logic [PHASES-1:0]         hi,
  output logic [PHASES-1:0]         lo,
  output logic [PHASES-1:0]         en
);

  typedef enum logic [2:0] {
    OFF,
    WAIT,
    LO_ON,
    DT_RISE,
    HI_ON,
    DT_FALL
  } state_t;

  logic pending;
  logic load;
  logic enable_q;

  assign load = (pending | update_req) & (carrier_peak | carrier_valley);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending    <= 1'b0;
      update_ack <= 1'b0;
      enable_q   <= 1'b0;
    end else begin
      pending    <= load ? 1'b0 : (pending | update_req);
      update_ack <= load;
      enable_q   <= enable;
    end
  end

  for (genvar g = 0; g < PHASES; g++) begin : g_ch
    // Counter-clockwise rotation swaps phases 1 and 2 at load time.
    localparam int ALT = (PHASES >= 3) ?
      ((g == 1) ? 2 : (g == 2) ? 1 : g) : g;

    logic [REF_W-1:0]            ref_sel;
    logic signed [REF_W-1:0]     shadow;
    logic signed [CARRIER_W-1:0] ref_ext;
    logic                        demand_q;
    state_t                      state;
    state_t                      state_nxt;
    logic [DT_W-1:0]             cnt;
    logic [DT_W-1:0]             cnt_nxt;
    logic                        hi_q;
    logic                        lo_q;
    logic                        en_q;

    assign ref_sel = dir_ccw ? refs[ALT*REF_W +: REF_W]
                             : refs[g*REF_W +: REF_W];
    assign ref_ext = CARRIER_W'(shadow);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow   <= '0;
        demand_q <= 1'b0;
      end else begin
        if (load) shadow <= ref_sel;
        demand_q <= ref_ext > $signed(carrier);
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
        OFF: begin
          if (enable_q) begin
            state_nxt = WAIT;
            cnt_nxt   = dead_time;
          end
        end
        WAIT, DT_RISE, DT_FALL: begin
          if (cnt != '0) cnt_nxt = cnt - DT_W'(1);
          else state_nxt = demand_q ? HI_ON : LO_ON;
        end
        LO_ON: begin
          if (demand_q) begin
            state_nxt = DT_RISE;
            cnt_nxt   = dead_time;
          end
        end
        HI_ON: begin
          if (!demand_q) begin
            state_nxt = DT_FALL;
            cnt_nxt   = dead_time;
          end
        end
        default: state_nxt = OFF;
      endcase
      if (!enable_q) state_nxt = OFF;
    end

    // Gate drives are decoded from the next state so they are registered
    // alongside the state and can never overlap.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state <= OFF;
        cnt   <= '0;
        hi_q  <= 1'b0;
        lo_q  <= 1'b0;
        en_q  <= 1'b0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
        hi_q  <= state_nxt == HI_ON;
        lo_q  <= state_nxt == LO_ON;
        en_q  <= state_nxt != OFF;
      end
    end

    assign hi[g] = hi_q;
    assign lo[g] = lo_q;
    assign en[g] = en_q;
  end

endmodule

// File: tb/tb_ac_motor_pwm_compare.sv
// Directed bench for ac_motor_pwm_compare: dead time, shadow handshake,
// direction swap, duty cycle and enable/reset behaviour.
module tb_ac_motor_pwm_compare;
  localparam int P  = 3;
  localparam int CW = 25;
  localparam int RW = 24;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset, enable, dir_ccw, update_req, update_ack;
  logic carrier_peak, carrier_valley;
  logic [CW-1:0] carrier;
  logic [P*RW-1:0] refs;
  logic [DW-1:0] dead_time;
  logic [P-1:0] hi, lo, en;

  logic tri_on = 1'b0;
  logic up = 1'b1;
  logic man_peak = 1'b0;
  logic man_valley = 1'b0;
  logic pv_prev = 1'b0;
  logic signed [CW-1:0] tri_val = '0;
  logic signed [CW-1:0] man_carrier = '0;
  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  assign carrier        = tri_on ? tri_val : man_carrier;
  assign carrier_peak   = tri_on ? (tri_val == CW'(4096)) : man_peak;
  assign carrier_valley = tri_on ? (tri_val == -CW'(4096)) : man_valley;

  ac_motor_pwm_compare #(
    .PHASES(P), .CARRIER_W(CW), .REF_W(RW), .DT_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir_ccw(dir_ccw),
    .carrier(carrier), .carrier_peak(carrier_peak),
    .carrier_valley(carrier_valley), .refs(refs),
    .dead_time(dead_time), .update_req(update_req),
    .update_ack(update_ack), .hi(hi), .lo(lo), .en(en)
  );

  always @(posedge clk) begin
    pv_prev <= carrier_peak | carrier_valley;
    if (update_ack) ack_cnt <= ack_cnt + 1;
    if (|(hi & lo)) overlap <= overlap + 1;
    if (!tri_on) begin
      tri_val <= '0;
      up <= 1'b1;
    end else if (up) begin
      tri_val <= tri_val + CW'(1);
      if (tri_val == CW'(4095)) up <= 1'b0;
    end else begin
      tri_val <= tri_val - CW'(1);
      if (tri_val == -CW'(4095)) up <= 1'b1;
    end
  end

  task automatic check(input string tag, input longint got,
                       input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [P*RW-1:0] pack(input int r0, input int r1,
                                           input int r2);
    return {RW'(r2), RW'(r1), RW'(r0)};
  endfunction

  task automatic do_reset(input logic [DW-1:0] dt);
    reset = 1'b1;
    enable = 1'b1;
    dead_time = dt;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts cycles with en high and both gates off before a gate asserts.
  task automatic wait_dead(output int n);
    int t = 0;
    n = 0;
    while (en[0] !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (en[0] !== 1'b1) begin
      n = -1;
      return;
    end
    while (hi[0] === 1'b0 && lo[0] === 1'b0 && n < 600) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic gap(input bit to_hi, input int chg_at,
                     input logic [DW-1:0] chg_dt, output int n);
    int t = 0;
    n = 0;
    man_carrier = to_hi ? -CW'(100) : CW'(100);
    while ((to_hi ? lo[0] : hi[0]) === 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    while (hi[0] === 1'b0 && lo[0] === 1'b0 && n < 600) begin
      n++;
      if (n == chg_at) dead_time = chg_dt;
      @(negedge clk);
    end
    if ((to_hi ? hi[0] : lo[0]) !== 1'b1) n = -1;
  endtask

  initial begin
    int n, base, t, diff;
    int cnt[P];
    int exp_hi[P];
    exp_hi = '{12191, 8191, 4191};

    reset = 1'b1;
    enable = 1'b1;
    dir_ccw = 1'b0;
    update_req = 1'b0;
    refs = '0;
    dead_time = 8'd3;
    man_carrier = -CW'(100);
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_en", en, 0);
    check("rst_ack", update_ack, 0);
    reset = 1'b0;
    wait_dead(n);
    check("rst_wait_len", n, 4);
    check("rst_then_hi", hi, 3'b111);
    check("rst_then_lo", lo, 0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_hi", hi, 0);
    check("async_rst_en", en, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_dead(n);
    check("rst_restart_wait", n, 4);

    for (int k = 0; k < 2; k++) begin
      logic [DW-1:0] d;
      d = (k == 0) ? 8'd0 : 8'd255;
      man_carrier = -CW'(100);
      do_reset(d);
      wait_dead(n);
      check("dt_wait", n, int'(d) + 1);
      gap(1'b0, 0, d, n);
      check("dt_fall", n, int'(d) + 1);
      gap(1'b1, 5, 8'd0, n);
      check("dt_rise", n, int'(d) + 1);
    end

    man_carrier = '0;
    do_reset(8'd0);
    repeat (10) @(negedge clk);
    check("lo_at_zero", lo, 3'b111);
    refs = pack(100, 2000, -2000);
    dir_ccw = 1'b1;
    update_req = 1'b1;
    man_peak = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    man_peak = 1'b0;
    dir_ccw = 1'b0;
    check("ack_coinc_peak", update_ack, 1);
    @(negedge clk);
    check("ack_one_cycle", update_ack, 0);
    repeat (10) @(negedge clk);
    check("ccw_hi", hi, 3'b101);
    check("ccw_lo", lo, 3'b010);

    update_req = 1'b1;
    man_valley = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    man_valley = 1'b0;
    check("ack_coinc_valley", update_ack, 1);
    repeat (10) @(negedge clk);
    check("cw_hi", hi, 3'b011);
    check("cw_lo", lo, 3'b100);

    base = ack_cnt;
    refs = pack(-500, -500, -500);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    repeat (3) @(negedge clk);
    check("ack_held", update_ack, 0);
    refs = pack(500, 500, -500);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    refs = pack(-100, 100, 100);
    repeat (3) @(negedge clk);
    check("ack_held2", update_ack, 0);
    man_peak = 1'b1;
    @(negedge clk);
    man_peak = 1'b0;
    check("ack_pending", update_ack, 1);
    repeat (10) @(negedge clk);
    check("ack_single_load", ack_cnt - base, 1);
    check("late_ref_hi", hi, 3'b110);
    check("late_ref_lo", lo, 3'b001);

    man_carrier = CW'(100);
    do_reset(8'd20);
    wait_dead(n);
    check("en_wait20", n, 21);
    check("en_lo", lo, 3'b111);
    man_carrier = -CW'(100);
    t = 0;
    while (lo[0] === 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("in_dt_rise", {hi[0], lo[0], en[0]}, 3'b001);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("dis_rise", {hi, lo, en}, 0);
    enable = 1'b1;
    wait_dead(n);
    check("reen_wait", n, 21);
    check("reen_hi", hi, 3'b111);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    check("dis_hi", {hi, lo, en}, 0);
    dead_time = 8'd2;
    enable = 1'b1;
    wait_dead(n);
    check("reen_wait2", n, 3);
    check("reen_hi2", hi, 3'b111);

    man_carrier = '0;
    do_reset(8'd3);
    tri_on = 1'b1;
    repeat (100) @(negedge clk);
    base = ack_cnt;
    refs = pack(2000, 0, -2000);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
    check("tri_ack_early", update_ack, 0);
    t = 0;
    while (update_ack !== 1'b1 && t < 9000) begin
      @(negedge clk);
      t++;
    end
    check("tri_ack_seen", update_ack, 1);
    check("tri_ack_at_pv", pv_prev, 1);
    repeat (50) @(negedge clk);
    cnt = '{0, 0, 0};
    for (int i = 0; i < 16384; i++) begin
      @(negedge clk);
      for (int c = 0; c < P; c++) if (hi[c] === 1'b1) cnt[c]++;
    end
    for (int c = 0; c < P; c++) begin
      diff = cnt[c] - exp_hi[c];
      if (diff < 0) diff = -diff;
      check($sformatf("duty%0d_cnt%0d", c, cnt[c]), diff <= 164, 1);
    end
    check("tri_ack_single", ack_cnt - base, 1);
    tri_on = 1'b0;

    @(negedge clk);
    check("no_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ac_motor_pwm_compare.md
# ac_motor_pwm_compare

Parametrised multi-phase PWM comparator for the AC motor path; supersedes the fixed single-phase comparator. Compares up to PHASES signed sine references against the shared triangle carrier, inserts programmable dead time per half-bridge, and latches new references only at carrier peak/valley through a request/acknowledge handshake. Sits between the triangle/sine generators and the gate-driver pins.

## Interface
- PHASES, 3, number of half-bridge channels (1..8)
- CARRIER_W, 25, signed carrier width
- REF_W, 24, signed reference width (REF_W <= CARRIER_W)
- DT_W, 8, dead-time counter width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  bridge enable; 0 forces all channels off
- dir_ccw  in  1  direction; 1 swaps channel 1 and channel 2 references at shadow load (PHASES >= 3 only)
- carrier  in  CARRIER_W  signed triangle carrier
- carrier_peak  in  1  one-cycle pulse at carrier maximum
- carrier_valley  in  1  one-cycle pulse at carrier minimum
- ref  in  PHASES*REF_W  packed signed references, channel i at [i*REF_W +: REF_W]
- dead_time  in  DT_W  dead interval minus one, in clk cycles
- update_req  in  1  one-cycle request to load ref into shadow
- update_ack  out  1  one-cycle pulse when shadow loaded
- hi  out  PHASES  high-side gate drive
- lo  out  PHASES  low-side gate drive
- en  out  PHASES  channel driver enable

## Operation
- Shadow: PHASES x REF_W register, reset 0. update_req sets pending. On a cycle with pending (or update_req) and carrier_peak or carrier_valley: shadow <= ref (channel 1/2 swapped if dir_ccw sampled that cycle), pending cleared, update_ack = 1 next cycle. update_req while pending: ignored. update_req coincident with peak/valley: loads that same cycle.
- Demand: demand_q[i] <= (sign-extend(shadow[i]) > carrier), registered each cycle. Equality means demand 0.
- Per-channel FSM, states OFF, WAIT, LO_ON, DT_RISE, HI_ON, DT_FALL. Counter DT_W bits.
  - OFF: hi=lo=en=0. enable=1 -> WAIT, counter <= dead_time.
  - WAIT/DT_RISE/DT_FALL: hi=lo=0, en=1. counter != 0: decrement. counter == 0: go HI_ON if demand_q else LO_ON.
  - LO_ON: lo=1. demand_q=1 -> DT_RISE, counter <= dead_time.
  - HI_ON: hi=1. demand_q=0 -> DT_FALL, counter <= dead_time.
  - Any state, enable=0 -> OFF (priority over all transitions).
- Dead interval = dead_time + 1 cycles; dead_time = 0 still gives one cycle with both off. hi and lo never both 1, including across enable and reset edges.
- Demand reversal during DT_RISE/DT_FALL: exit decision uses demand_q at counter==0; return to the original side is legal and still costs the full dead interval.
- dead_time sampled only at counter load; change mid-interval has no effect on that interval.

## Timing
- Reset values: hi=0, lo=0, en=0, update_ack=0, all FSMs OFF, shadow=0, pending=0.
- hi/lo/en are registered FSM decodes.
- Carrier crossing sampled on edge k -> demand_q after k -> state change on edge k+1 -> outputs change after edge k+1 (2-cycle latency to entering dead time).
- enable deassert sampled on edge k -> all outputs 0 after edge k+1.
- Shadow load on peak/valley edge k -> update_ack high for edge k+1 only; new value affects demand_q from edge k+1.
- Reset mid-dead-interval or mid-ON: outputs drop immediately (async), FSM restarts via WAIT after release with enable=1.

## Test plan
- Reset with enable=1, dead_time=3, shadow 0, carrier held at -100 -> after release: en=1, hi=lo=0 for 4 cycles, then hi=1.
- Carrier 25-bit triangle +/-4096, step 1; update_req with refs {2000, 0, -2000} -> update_ack at next peak/valley only; hi duty per channel ~74%, 50%, 26% within 1%.
- dead_time=0 and dead_time=255 -> every hi/lo edge separated by exactly 1 and 256 cycles of both low; assert hi&lo never true.
- dir_ccw=1, refs {100, 2000, -2000} -> shadow ch1=-2000, ch2=2000; ch1/ch2 outputs swapped vs dir_ccw=0.
- update_req pulsed twice before peak, and once coincident with valley -> single ack per load, load on the coincident cycle.
- enable dropped during DT_RISE and during HI_ON -> all outputs 0 one cycle later; re-enable passes through WAIT before any output asserts.
